// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit sides: line-rate defaults,
// bit-level FSM state encoding and a width helper.
package uart_pkg;

   localparam int CLK_HZ        = 12_000_000;
   localparam int BAUD          = 9600;
   localparam int DEFAULT_RATIO = CLK_HZ / BAUD;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   // Counter/index width for n distinct values; never narrower than one bit.
   function automatic int width_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Serial line synchroniser and bit-level deframer; strobes a byte or a frame error at the final stop-bit mid-sample.
// Latency: 3 clk synchroniser/edge delay into the bit timer; no backpressure, strobes are single-cycle and must be consumed.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int RATIO     = DEFAULT_RATIO,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] o_byte,
   output logic                 o_byte_vld,
   output logic                 o_frame_err,
   output logic                 o_busy
);

   localparam int TMR_W = width_min1(RATIO);
   localparam int CNT_W = width_min1((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(RATIO - 1);
   localparam logic [TMR_W-1:0] TMR_HALF  = TMR_W'(RATIO / 2 - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

   logic                 r_sync1;
   logic                 r_sync2;
   logic                 r_rx_d;
   uart_state_t          r_state;
   logic [TMR_W-1:0]     r_timer;
   logic [CNT_W-1:0]     r_cnt;
   logic [DATA_BITS-1:0] r_shift;

   uart_state_t w_state_nxt;
   logic        w_fall;
   logic        w_tmr_clr;
   logic        w_shift;
   logic        w_cnt_clr;
   logic        w_cnt_inc;
   logic        w_byte_vld;
   logic        w_frame_err;

   // Edge register sits after the synchroniser so a line held low cannot retrigger.
   assign w_fall = r_rx_d & ~r_sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_rx_d  <= 1'b1;
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_cnt   <= '0;
         r_shift <= '0;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_rx_d  <= r_sync2;
         r_state <= w_state_nxt;
         if (w_tmr_clr || r_state == ST_IDLE) r_timer <= '0;
         else                                 r_timer <= r_timer + 1'b1;
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
         if (w_shift) r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_clr   = 1'b0;
      w_shift     = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_byte_vld  = 1'b0;
      w_frame_err = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_fall) begin
               w_state_nxt = ST_START;
               w_tmr_clr   = 1'b1;
            end
         end
         ST_START: begin
            if (r_timer == TMR_HALF) begin
               w_tmr_clr = 1'b1;
               if (r_sync2) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_DATA;
                  w_cnt_clr   = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (r_timer == TMR_LAST) begin
               w_tmr_clr = 1'b1;
               w_shift   = 1'b1;
               if (r_cnt == DATA_LAST) begin
                  w_state_nxt = ST_STOP;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         ST_STOP: begin
            // Leaving at the mid-sample of the last stop bit leaves half a bit to catch the next start edge.
            if (r_timer == TMR_LAST) begin
               w_tmr_clr = 1'b1;
               if (!r_sync2) begin
                  w_frame_err = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (r_cnt == STOP_LAST) begin
                  w_byte_vld  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_byte      = r_shift;
   assign o_byte_vld  = w_byte_vld;
   assign o_frame_err = w_frame_err;
   assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver assembling consecutive bytes (first byte in the low slot) into one word, with idle timeout on partial words.
// Latency: data_valid 1 clk after the final stop-bit mid-sample of the last byte; no backpressure, data_valid is a 1-clk strobe.
module uart_rx_word
   import uart_pkg::*;
#(
   parameter int BAUD_2_CLOCK_RATIO = DEFAULT_RATIO,
   parameter int UART_DATA_BITS     = 8,
   parameter int UART_STOP_BITS     = 2,
   parameter int OUTPUT_DATA_WIDTH  = 16,
   parameter int TIMEOUT_BITS       = 20
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rx,
   output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
   output logic                         data_valid,
   output logic                         frame_err,
   output logic                         busy
);

   localparam int BYTES   = OUTPUT_DATA_WIDTH / UART_DATA_BITS;
   localparam int IDX_W   = width_min1(BYTES);
   localparam int TO_CLKS = TIMEOUT_BITS * BAUD_2_CLOCK_RATIO;
   localparam int TO_W    = $clog2(TO_CLKS + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CLKS - 1);

   logic [OUTPUT_DATA_WIDTH-1:0] r_asm;
   logic [IDX_W-1:0]             r_idx;
   logic [TO_W-1:0]              r_to_cnt;

   logic [UART_DATA_BITS-1:0]    w_byte;
   logic                         w_byte_vld;
   logic                         w_frame_err;
   logic                         w_busy;
   logic                         w_to_expire;
   logic [OUTPUT_DATA_WIDTH-1:0] w_word;

   uart_rx_byte #(
      .RATIO     (BAUD_2_CLOCK_RATIO),
      .DATA_BITS (UART_DATA_BITS),
      .STOP_BITS (UART_STOP_BITS)
   ) u_rx_byte (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .o_byte      (w_byte),
      .o_byte_vld  (w_byte_vld),
      .o_frame_err (w_frame_err),
      .o_busy      (w_busy)
   );

   assign busy = w_busy;

   // Only counts in IDLE, so it can never coincide with a byte or frame-error strobe.
   assign w_to_expire = ~w_busy & (r_idx != '0) & (r_to_cnt == TO_LAST);

   always_comb begin
      w_word = r_asm;
      w_word[r_idx*UART_DATA_BITS +: UART_DATA_BITS] = w_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_asm      <= '0;
         r_idx      <= '0;
         r_to_cnt   <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= w_frame_err;
         if (w_byte_vld) begin
            r_asm <= w_word;
            if (r_idx == IDX_LAST) begin
               r_idx      <= '0;
               data_out   <= w_word;
               data_valid <= 1'b1;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end else if (w_frame_err || w_to_expire) begin
            r_idx <= '0;
         end
         if (w_busy || r_idx == '0 || w_to_expire) r_to_cnt <= '0;
         else                                      r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed and randomized bench for uart_rx_word; a byte-level model predicts the words from the frames sent.
// The bit period is shortened to keep run time small; sender periods of +-1 clk exercise baud mismatch.
`timescale 1ns/1ps
module tb_uart_rx_word;

   localparam int PER     = 40;
   localparam int TO_BITS = 20;
   localparam int W       = 16;
   localparam int NB      = W / 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rx;
   logic [W-1:0] data_out;
   logic         data_valid;
   logic         frame_err;
   logic         busy;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] got_q[$];
   logic [W-1:0] exp_q[$];
   logic [7:0]   part_q[$];
   int           busy_runs_q[$];
   int           got_rd   = 0;
   int           fe_cnt   = 0;
   int           both_cnt = 0;
   int           busy_run = 0;
   int           gap_clks = 0;

   uart_rx_word #(
      .BAUD_2_CLOCK_RATIO (PER),
      .UART_DATA_BITS     (8),
      .UART_STOP_BITS     (2),
      .OUTPUT_DATA_WIDTH  (W),
      .TIMEOUT_BITS       (TO_BITS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #41.667 clk = ~clk;

   always @(negedge clk) begin
      if (data_valid) got_q.push_back(data_out);
      if (frame_err) fe_cnt++;
      if (data_valid && frame_err) both_cnt++;
      if (busy) begin
         busy_run++;
      end else if (busy_run != 0) begin
         busy_runs_q.push_back(busy_run);
         busy_run = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int per);
      rx = v;
      repeat (per) @(negedge clk);
   endtask

   task automatic idle_bits(input int n, input int per);
      rx = 1'b1;
      repeat (n * per) @(negedge clk);
      gap_clks += n * per;
   endtask

   // Sends one 8N2 frame and updates the word model: a bad stop bit drops the partial word,
   // a long idle gap discards it, and every NB good bytes form a word, first byte lowest.
   task automatic send_byte(input logic [7:0] b, input int per, input bit bad_stop);
      logic [W-1:0] w;
      drive_bit(1'b0, per);
      for (int i = 0; i < 8; i++) drive_bit(b[i], per);
      drive_bit(!bad_stop, per);
      drive_bit(1'b1, per);
      if (bad_stop) begin
         part_q.delete();
      end else begin
         if (part_q.size() != 0 && gap_clks + per / 2 >= TO_BITS * PER) part_q.delete();
         part_q.push_back(b);
         if (part_q.size() == NB) begin
            w = '0;
            for (int k = 0; k < NB; k++) w[k*8 +: 8] = part_q[k];
            exp_q.push_back(w);
            part_q.delete();
         end
      end
      gap_clks = 0;
   endtask

   task automatic check_words(input string tag);
      chk({tag, "_count"}, 32'(got_q.size() - got_rd), 32'(exp_q.size()));
      while (exp_q.size() != 0 && got_rd < got_q.size()) begin
         chk({tag, "_word"}, 32'(got_q[got_rd]), 32'(exp_q.pop_front()));
         got_rd++;
      end
      got_rd = got_q.size();
      exp_q.delete();
   endtask

   initial begin
      int         fe_base;
      int         nruns;
      int         per;
      logic [7:0] b0;
      logic [7:0] b1;

      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_data_valid", 32'(data_valid), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      idle_bits(2, PER);

      // Two bytes back-to-back form one word; checked right after the frame ends.
      fe_base = fe_cnt;
      send_byte(8'h34, PER, 1'b0);
      send_byte(8'h12, PER, 1'b0);
      repeat (4) @(negedge clk);
      check_words("t1");
      chk("t1_frame_err", 32'(fe_cnt - fe_base), 32'h0);
      idle_bits(3, PER);

      // Short low glitch: start is rejected at the half-bit sample.
      fe_base = fe_cnt;
      nruns   = busy_runs_q.size();
      rx = 1'b0;
      repeat (10) @(negedge clk);
      idle_bits(3, PER);
      chk("t2_words", 32'(got_q.size() - got_rd), 32'h0);
      chk("t2_frame_err", 32'(fe_cnt - fe_base), 32'h0);
      chk("t2_busy_idle", 32'(busy), 32'h0);
      chk("t2_busy_runs", 32'(busy_runs_q.size() - nruns), 32'h1);
      if (busy_runs_q.size() > nruns)
         chk("t2_busy_len", 32'((busy_runs_q[nruns] > 0) && (busy_runs_q[nruns] <= PER)), 32'h1);

      // Bad first stop bit drops that byte; the next two form the word.
      fe_base = fe_cnt;
      send_byte(8'h77, PER, 1'b1);
      send_byte(8'hCD, PER, 1'b0);
      send_byte(8'hAB, PER, 1'b0);
      repeat (4) @(negedge clk);
      check_words("t3");
      chk("t3_frame_err", 32'(fe_cnt - fe_base), 32'h1);

      // A lone byte followed by a long idle gap is discarded.
      idle_bits(2, PER);
      send_byte(8'h55, PER, 1'b0);
      idle_bits(25, PER);
      send_byte(8'h34, PER, 1'b0);
      send_byte(8'h12, PER, 1'b0);
      repeat (4) @(negedge clk);
      check_words("t4");
      chk("t4_data_out_hold", 32'(data_out), 32'h1234);

      // Reset in the middle of data bit 3 of a frame.
      idle_bits(2, PER);
      b0 = 8'h0F;
      drive_bit(1'b0, PER);
      for (int i = 0; i < 3; i++) drive_bit(b0[i], PER);
      rx = b0[3];
      repeat (PER / 2) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_rst_data_out", 32'(data_out), 32'h0);
      chk("t5_rst_data_valid", 32'(data_valid), 32'h0);
      chk("t5_rst_frame_err", 32'(frame_err), 32'h0);
      chk("t5_rst_busy", 32'(busy), 32'h0);
      repeat (7) @(negedge clk);
      rst_n = 1'b1;
      part_q.delete();
      idle_bits(3, PER);
      send_byte(8'h0F, PER, 1'b0);
      send_byte(8'hF0, PER, 1'b0);
      repeat (4) @(negedge clk);
      check_words("t5");

      // Random words from a sender running slightly fast, then slightly slow.
      for (int p = 0; p < 2; p++) begin
         per     = (p == 0) ? PER - 1 : PER + 1;
         fe_base = fe_cnt;
         idle_bits(2, per);
         for (int n = 0; n < 25; n++) begin
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            send_byte(b0, per, 1'b0);
            send_byte(b1, per, 1'b0);
         end
         idle_bits(2, per);
         check_words((p == 0) ? "t6_fast" : "t6_slow");
         chk((p == 0) ? "t6_fast_frame_err" : "t6_slow_frame_err", 32'(fe_cnt - fe_base), 32'h0);
      end

      chk("valid_with_frame_err", 32'(both_cnt), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
